// File: rtl/dma_cmd_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : dma_cmd_arbiter
// Purpose  : Shares a single dma_engine command interface among NUM_REQ
//            requesters. Round-robin arbitration picks a requester, its
//            descriptor is latched, then dma_enqueue and dma_start are pulsed.
//            The arbiter waits for dma_done and returns a one-cycle req_done
//            pulse to the owner.
// Ports    : clk, rst (async, active high)
//            req_valid/req_ready/req_done  per-requester handshake (one-hot)
//            req_mode, req_int_addr, req_ext_addr, req_len, req_stride,
//            req_seg_count, req_seg_stride  packed descriptors (slice i)
//            busy, owner                    status
//            dma_enqueue, dma_start, dma_* descriptor  to dma_engine
//            dma_done, dma_idle, dma_queue_full        from dma_engine
// Options  : DMA_ARB_STATS_EN adds stat_xfers and stat_stall (32-bit,
//            saturating) counters.
// Revision : 1.0 - initial release
// =============================================================================
module dma_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [2*NUM_REQ-1:0]      req_mode,
  input  logic [ADDR_W*NUM_REQ-1:0] req_int_addr,
  input  logic [ADDR_W*NUM_REQ-1:0] req_ext_addr,
  input  logic [CNT_W*NUM_REQ-1:0]  req_len,
  input  logic [CNT_W*NUM_REQ-1:0]  req_stride,
  input  logic [CNT_W*NUM_REQ-1:0]  req_seg_count,
  input  logic [CNT_W*NUM_REQ-1:0]  req_seg_stride,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      busy,
  output logic [2:0]                owner,
  output logic                      dma_enqueue,
  output logic                      dma_start,
  output logic [1:0]                dma_mode,
  output logic [ADDR_W-1:0]         dma_int_addr,
  output logic [ADDR_W-1:0]         dma_ext_addr,
  output logic [CNT_W-1:0]          dma_len,
  output logic [CNT_W-1:0]          dma_stride,
  output logic [CNT_W-1:0]          dma_offset,
  output logic [CNT_W-1:0]          dma_seg_count,
  output logic [CNT_W-1:0]          dma_seg_stride,
  input  logic                      dma_done,
  input  logic                      dma_idle,
  input  logic                      dma_queue_full
`ifdef DMA_ARB_STATS_EN
  ,
  output logic [31:0]               stat_xfers,
  output logic [31:0]               stat_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_ENQ   = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_rr_ptr;
  logic [2:0]          r_owner;
  logic [NUM_REQ-1:0]  r_req_ready;
  logic [NUM_REQ-1:0]  r_req_done;
  logic                r_enqueue;
  logic                r_start;
  logic [1:0]          r_mode;
  logic [ADDR_W-1:0]   r_int_addr;
  logic [ADDR_W-1:0]   r_ext_addr;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_stride;
  logic [CNT_W-1:0]    r_seg_count;
  logic [CNT_W-1:0]    r_seg_stride;

  logic                w_found;
  logic [2:0]          w_gnt;
  logic [2:0]          w_ptr_nxt;
  logic [NUM_REQ-1:0]  w_gnt_oh;
  logic [NUM_REQ-1:0]  w_own_oh;
  logic [1:0]          w_sel_mode;
  logic [ADDR_W-1:0]   w_sel_int_addr;
  logic [ADDR_W-1:0]   w_sel_ext_addr;
  logic [CNT_W-1:0]    w_sel_len;
  logic [CNT_W-1:0]    w_sel_stride;
  logic [CNT_W-1:0]    w_sel_seg_count;
  logic [CNT_W-1:0]    w_sel_seg_stride;
  logic                w_latch;
  logic [NUM_REQ-1:0]  w_ready_nxt;
  logic [NUM_REQ-1:0]  w_done_nxt;
  logic                w_enq_nxt;
  logic                w_start_nxt;

  // Round-robin pick: first pass looks at indices at/after the pointer, the
  // second pass wraps to the lowest valid index below it.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i] && (3'(i) >= r_rr_ptr)) begin
        w_found = 1'b1;
        w_gnt   = 3'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found = 1'b1;
        w_gnt   = 3'(i);
      end
    end
    w_ptr_nxt = (w_gnt == 3'(NUM_REQ - 1)) ? 3'd0 : (w_gnt + 3'd1);
  end

  // Descriptor slice mux and one-hot decodes of the grant and the owner.
  always_comb begin
    w_gnt_oh         = '0;
    w_own_oh         = '0;
    w_sel_mode       = '0;
    w_sel_int_addr   = '0;
    w_sel_ext_addr   = '0;
    w_sel_len        = '0;
    w_sel_stride     = '0;
    w_sel_seg_count  = '0;
    w_sel_seg_stride = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_own_oh[i] = (r_owner == 3'(i));
      if (w_gnt == 3'(i)) begin
        w_gnt_oh[i]      = w_found;
        w_sel_mode       = req_mode[2*i +: 2];
        w_sel_int_addr   = req_int_addr[ADDR_W*i +: ADDR_W];
        w_sel_ext_addr   = req_ext_addr[ADDR_W*i +: ADDR_W];
        w_sel_len        = req_len[CNT_W*i +: CNT_W];
        w_sel_stride     = req_stride[CNT_W*i +: CNT_W];
        w_sel_seg_count  = req_seg_count[CNT_W*i +: CNT_W];
        w_sel_seg_stride = req_seg_stride[CNT_W*i +: CNT_W];
      end
    end
  end

  // Next state plus next values of the registered pulse outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_ready_nxt = '0;
    w_done_nxt  = '0;
    w_enq_nxt   = 1'b0;
    w_start_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((|req_valid) && dma_idle) w_state_nxt = S_ARB;
      end
      S_ARB: begin
        if (w_found) begin
          w_latch     = 1'b1;
          w_ready_nxt = w_gnt_oh;
          w_state_nxt = S_ENQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ENQ: begin
        if (!dma_queue_full) begin
          w_enq_nxt   = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_start_nxt = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (dma_done) begin
          w_done_nxt  = w_own_oh;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr     <= 3'd0;
      r_owner      <= 3'd0;
      r_req_ready  <= '0;
      r_req_done   <= '0;
      r_enqueue    <= 1'b0;
      r_start      <= 1'b0;
      r_mode       <= '0;
      r_int_addr   <= '0;
      r_ext_addr   <= '0;
      r_len        <= '0;
      r_stride     <= '0;
      r_seg_count  <= '0;
      r_seg_stride <= '0;
    end else begin
      r_req_ready <= w_ready_nxt;
      r_req_done  <= w_done_nxt;
      r_enqueue   <= w_enq_nxt;
      r_start     <= w_start_nxt;
      if (w_latch) begin
        r_rr_ptr     <= w_ptr_nxt;
        r_owner      <= w_gnt;
        r_mode       <= w_sel_mode;
        r_int_addr   <= w_sel_int_addr;
        r_ext_addr   <= w_sel_ext_addr;
        r_len        <= w_sel_len;
        r_stride     <= w_sel_stride;
        r_seg_count  <= w_sel_seg_count;
        r_seg_stride <= w_sel_seg_stride;
      end
    end
  end

  assign req_ready      = r_req_ready;
  assign req_done       = r_req_done;
  assign busy           = (r_state != S_IDLE);
  assign owner          = r_owner;
  assign dma_enqueue    = r_enqueue;
  assign dma_start      = r_start;
  assign dma_mode       = r_mode;
  assign dma_int_addr   = r_int_addr;
  assign dma_ext_addr   = r_ext_addr;
  assign dma_len        = r_len;
  assign dma_stride     = r_stride;
  assign dma_offset     = '0;
  assign dma_seg_count  = r_seg_count;
  assign dma_seg_stride = r_seg_stride;

`ifdef DMA_ARB_STATS_EN
  localparam logic [31:0] c_SAT = 32'hFFFF_FFFF;

  logic [31:0] r_stat_xfers;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_xfers <= 32'd0;
      r_stat_stall <= 32'd0;
    end else begin
      if ((r_state == S_WAIT) && dma_done && (r_stat_xfers != c_SAT))
        r_stat_xfers <= r_stat_xfers + 32'd1;
      if ((r_state == S_ENQ) && dma_queue_full && (r_stat_stall != c_SAT))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_xfers = r_stat_xfers;
  assign stat_stall = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dma_cmd_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_dma_cmd_arbiter
// Purpose  : Self-checking bench for dma_cmd_arbiter. Expected grants and
//            completions are queued when requests are raised and popped when
//            req_ready / req_done appear. A small engine model answers
//            dma_start with dma_done after eng_delay cycles.
// Revision : 1.0 - initial release
// =============================================================================
module tb_dma_cmd_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 64;
  localparam int CNT_W   = 32;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [2*NUM_REQ-1:0]      req_mode;
  logic [ADDR_W*NUM_REQ-1:0] req_int_addr;
  logic [ADDR_W*NUM_REQ-1:0] req_ext_addr;
  logic [CNT_W*NUM_REQ-1:0]  req_len;
  logic [CNT_W*NUM_REQ-1:0]  req_stride;
  logic [CNT_W*NUM_REQ-1:0]  req_seg_count;
  logic [CNT_W*NUM_REQ-1:0]  req_seg_stride;
  logic [NUM_REQ-1:0]        req_done;
  logic                      busy;
  logic [2:0]                owner;
  logic                      dma_enqueue;
  logic                      dma_start;
  logic [1:0]                dma_mode;
  logic [ADDR_W-1:0]         dma_int_addr;
  logic [ADDR_W-1:0]         dma_ext_addr;
  logic [CNT_W-1:0]          dma_len;
  logic [CNT_W-1:0]          dma_stride;
  logic [CNT_W-1:0]          dma_offset;
  logic [CNT_W-1:0]          dma_seg_count;
  logic [CNT_W-1:0]          dma_seg_stride;
  logic                      dma_done;
  logic                      dma_idle;
  logic                      dma_queue_full;
`ifdef DMA_ARB_STATS_EN
  logic [31:0]               stat_xfers;
  logic [31:0]               stat_stall;
`endif

  int checks = 0;
  int errors = 0;
  int eng_delay = 3;
  int eng_cnt = 0;
  int                 exp_grant[$];
  logic [NUM_REQ-1:0] exp_done[$];

  always #5 clk = ~clk;

  dma_cmd_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_int_addr(req_int_addr), .req_ext_addr(req_ext_addr),
    .req_len(req_len), .req_stride(req_stride),
    .req_seg_count(req_seg_count), .req_seg_stride(req_seg_stride),
    .req_done(req_done), .busy(busy), .owner(owner),
    .dma_enqueue(dma_enqueue), .dma_start(dma_start),
    .dma_mode(dma_mode), .dma_int_addr(dma_int_addr), .dma_ext_addr(dma_ext_addr),
    .dma_len(dma_len), .dma_stride(dma_stride), .dma_offset(dma_offset),
    .dma_seg_count(dma_seg_count), .dma_seg_stride(dma_seg_stride),
    .dma_done(dma_done), .dma_idle(dma_idle), .dma_queue_full(dma_queue_full)
`ifdef DMA_ARB_STATS_EN
    , .stat_xfers(stat_xfers), .stat_stall(stat_stall)
`endif
  );

  // Engine model: dma_done is driven eng_delay cycles after dma_start is seen.
  initial begin
    dma_done = 1'b0;
    forever begin
      @(negedge clk);
      dma_done = 1'b0;
      if (rst === 1'b1) begin
        eng_cnt = 0;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) dma_done = 1'b1;
      end else if (dma_start === 1'b1) begin
        eng_cnt = eng_delay;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_desc(input int i, input logic [1:0] m, input logic [63:0] ia,
                          input logic [63:0] ea, input logic [31:0] ln, input logic [31:0] st,
                          input logic [31:0] sc, input logic [31:0] ss);
    req_mode[2*i +: 2]                = m;
    req_int_addr[ADDR_W*i +: ADDR_W]  = ia;
    req_ext_addr[ADDR_W*i +: ADDR_W]  = ea;
    req_len[CNT_W*i +: CNT_W]         = ln;
    req_stride[CNT_W*i +: CNT_W]      = st;
    req_seg_count[CNT_W*i +: CNT_W]   = sc;
    req_seg_stride[CNT_W*i +: CNT_W]  = ss;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    dma_queue_full = 1'b0;
    dma_idle = 1'b1;
    eng_delay = 3;
    for (int i = 0; i < NUM_REQ; i++)
      set_desc(i, 2'(i), 64'h100 * (i + 1), 64'h8000_0000 + i, 32'(16 + i), 32'd4,
               32'(1 + i), 32'd64);
    exp_grant.delete();
    exp_done.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    dma_queue_full = 1'b0;
    dma_idle = 1'b1;
    req_mode = '1; req_int_addr = '1; req_ext_addr = '1; req_len = '1;
    req_stride = '1; req_seg_count = '1; req_seg_stride = '1;
    tick();
    tick();
    checks++;
    if (req_ready !== '0 || req_done !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: ready=%b done=%b busy=%b, required 0/0/0", req_ready, req_done, busy);
    end
    checks++;
    if (owner !== 3'd0 || dma_enqueue !== 1'b0 || dma_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: owner=%0d enq=%b start=%b, required 0/0/0", owner, dma_enqueue, dma_start);
    end
    checks++;
    if ({dma_mode, dma_int_addr, dma_ext_addr, dma_len, dma_stride, dma_offset,
         dma_seg_count, dma_seg_stride} !== '0) begin
      errors++;
      $display("FAIL reset_desc: mode=%0d int=%h ext=%h len=%0d, required all zero", dma_mode, dma_int_addr, dma_ext_addr, dma_len);
    end
`ifdef DMA_ARB_STATS_EN
    checks++;
    if (stat_xfers !== 32'd0 || stat_stall !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats: xfers=%0d stall=%0d, required 0/0", stat_xfers, stat_stall);
    end
`endif
    req_valid = '0;
  endtask

  task automatic test_single();
    int c;
    int e;
    logic [NUM_REQ-1:0] oh;
    apply_reset();
    set_desc(0, 2'd1, 64'h1234_0000, 64'h5678_0000, 32'd2, 32'd8, 32'd1, 32'd0);
    eng_delay = 5;
    req_valid[0] = 1'b1;
    exp_grant.push_back(0);
    c = 0;
    do begin tick(); c++; end while (req_ready == '0 && c < 10);
    e = exp_grant.pop_front();
    oh = '0; oh[e] = 1'b1;
    checks++;
    if (c != 2 || req_ready !== oh) begin
      errors++;
      $display("FAIL single_ready: cycles=%0d ready=%b, required cycles=2 ready=%b", c, req_ready, oh);
    end
    exp_done.push_back(oh);
    req_valid[0] = 1'b0;
    checks++;
    if (dma_mode !== 2'd1 || dma_len !== 32'd2 || dma_int_addr !== 64'h1234_0000 ||
        dma_stride !== 32'd8 || busy !== 1'b1 || owner !== 3'd0) begin
      errors++;
      $display("FAIL single_desc: mode=%0d len=%0d int=%h stride=%0d busy=%b owner=%0d, required 1/2/1234_0000/8/1/0",
               dma_mode, dma_len, dma_int_addr, dma_stride, busy, owner);
    end
    tick();
    checks++;
    if (dma_enqueue !== 1'b1 || dma_start !== 1'b0) begin
      errors++;
      $display("FAIL single_enq: enq=%b start=%b, required 1/0", dma_enqueue, dma_start);
    end
    tick();
    checks++;
    if (dma_enqueue !== 1'b0 || dma_start !== 1'b1) begin
      errors++;
      $display("FAIL single_start: enq=%b start=%b, required 0/1", dma_enqueue, dma_start);
    end
    c = 0;
    do begin tick(); c++; end while (req_done == '0 && c < 20);
    oh = exp_done.pop_front();
    checks++;
    if (c != 6 || req_done !== oh || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: cycles=%0d done=%b busy=%b, required cycles=6 done=%b busy=0", c, req_done, busy, oh);
    end
    tick();
    checks++;
    if (req_done !== '0 || dma_start !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse: done=%b start=%b, required 0/0", req_done, dma_start);
    end
  endtask

  task automatic test_round_robin();
    int g;
    int d;
    int c;
    int e;
    logic [NUM_REQ-1:0] oh;
    apply_reset();
    eng_delay = 2;
    exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
    exp_grant.push_back(3); exp_grant.push_back(0);
    req_valid = '1;
    g = 0; d = 0; c = 0;
    while ((g < 5 || d < 5) && c < 300) begin
      tick();
      c++;
      if (req_ready != '0) begin
        checks++;
        if (exp_grant.size() == 0) begin
          errors++;
          $display("FAIL rr_grant: unexpected ready=%b, required none", req_ready);
        end else begin
          e = exp_grant.pop_front();
          oh = '0; oh[e] = 1'b1;
          if (req_ready !== oh || owner !== 3'(e)) begin
            errors++;
            $display("FAIL rr_grant: ready=%b owner=%0d, required ready=%b owner=%0d", req_ready, owner, oh, e);
          end
          exp_done.push_back(oh);
        end
        g++;
        if (g == 5) req_valid = '0;
      end
      if (req_done != '0) begin
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL rr_done: unexpected done=%b, required none", req_done);
        end else begin
          oh = exp_done.pop_front();
          if (req_done !== oh) begin
            errors++;
            $display("FAIL rr_done: done=%b, required %b", req_done, oh);
          end
        end
        d++;
      end
    end
    checks++;
    if (g != 5 || d != 5) begin
      errors++;
      $display("FAIL rr_count: grants=%0d dones=%0d, required 5/5", g, d);
    end
  endtask

  task automatic test_queue_full();
    int c;
    int e;
    logic [NUM_REQ-1:0] oh;
    apply_reset();
    dma_queue_full = 1'b1;
    req_valid[0] = 1'b1;
    exp_grant.push_back(0);
    c = 0;
    do begin tick(); c++; end while (req_ready == '0 && c < 10);
    e = exp_grant.pop_front();
    oh = '0; oh[e] = 1'b1;
    checks++;
    if (req_ready !== oh) begin
      errors++;
      $display("FAIL qf_grant: ready=%b, required %b", req_ready, oh);
    end
    exp_done.push_back(oh);
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (dma_enqueue !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL qf_hold: cycle=%0d enq=%b busy=%b, required 0/1", k, dma_enqueue, busy);
      end
    end
    dma_queue_full = 1'b0;
    tick();
    checks++;
    if (dma_enqueue !== 1'b1) begin
      errors++;
      $display("FAIL qf_enq: enq=%b, required 1", dma_enqueue);
    end
    tick();
    checks++;
    if (dma_enqueue !== 1'b0 || dma_start !== 1'b1) begin
      errors++;
      $display("FAIL qf_start: enq=%b start=%b, required 0/1", dma_enqueue, dma_start);
    end
`ifdef DMA_ARB_STATS_EN
    checks++;
    if (stat_stall !== 32'd3) begin
      errors++;
      $display("FAIL qf_stat_stall: stall=%0d, required 3", stat_stall);
    end
`endif
    c = 0;
    do begin tick(); c++; end while (req_done == '0 && c < 20);
    oh = exp_done.pop_front();
    checks++;
    if (req_done !== oh) begin
      errors++;
      $display("FAIL qf_done: done=%b, required %b", req_done, oh);
    end
`ifdef DMA_ARB_STATS_EN
    checks++;
    if (stat_xfers !== 32'd1) begin
      errors++;
      $display("FAIL qf_stat_xfers: xfers=%0d, required 1", stat_xfers);
    end
`endif
  endtask

  task automatic test_idle_hold();
    int c;
    int bad;
    int e;
    logic [NUM_REQ-1:0] oh;
    apply_reset();
    dma_idle = 1'b0;
    req_valid[2] = 1'b1;
    exp_grant.push_back(2);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (req_ready !== '0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_hold: %0d cycles with grant/busy while engine busy, required 0", bad);
    end
    dma_idle = 1'b1;
    c = 0;
    do begin tick(); c++; end while (req_ready == '0 && c < 10);
    e = exp_grant.pop_front();
    oh = '0; oh[e] = 1'b1;
    checks++;
    if (c != 2 || req_ready !== oh || owner !== 3'(e)) begin
      errors++;
      $display("FAIL idle_grant: cycles=%0d ready=%b owner=%0d, required cycles=2 ready=%b owner=%0d", c, req_ready, owner, oh, e);
    end
    exp_done.push_back(oh);
    req_valid = '0;
    c = 0;
    do begin tick(); c++; end while (req_done == '0 && c < 20);
    oh = exp_done.pop_front();
    checks++;
    if (req_done !== oh) begin
      errors++;
      $display("FAIL idle_done: done=%b, required %b", req_done, oh);
    end
  endtask

  task automatic test_rst_wait();
    int c;
    int bad;
    int e;
    logic [NUM_REQ-1:0] oh;
    apply_reset();
    eng_delay = 10;
    req_valid[1] = 1'b1;
    exp_grant.push_back(1);
    c = 0;
    do begin tick(); c++; end while (req_ready == '0 && c < 10);
    e = exp_grant.pop_front();
    oh = '0; oh[e] = 1'b1;
    checks++;
    if (req_ready !== oh) begin
      errors++;
      $display("FAIL rstw_grant: ready=%b, required %b", req_ready, oh);
    end
    req_valid = '0;
    c = 0;
    do begin tick(); c++; end while (dma_start == 1'b0 && c < 10);
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0 || req_done !== '0 || busy !== 1'b0 || owner !== 3'd0 ||
        dma_start !== 1'b0 || dma_ext_addr !== '0 || dma_len !== '0) begin
      errors++;
      $display("FAIL rstw_async: ready=%b done=%b busy=%b owner=%0d start=%b ext=%h len=%0d, required all 0",
               req_ready, req_done, busy, owner, dma_start, dma_ext_addr, dma_len);
    end
    bad = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (k == 1) rst = 1'b0;
      if (req_done !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstw_no_done: %0d cycles with req_done after reset, required 0", bad);
    end
    req_valid = 4'b0101;
    exp_grant.push_back(0);
    c = 0;
    do begin tick(); c++; end while (req_ready == '0 && c < 10);
    e = exp_grant.pop_front();
    oh = '0; oh[e] = 1'b1;
    checks++;
    if (req_ready !== oh) begin
      errors++;
      $display("FAIL rstw_rr_restart: ready=%b, required %b", req_ready, oh);
    end
    exp_done.push_back(oh);
    req_valid = '0;
    c = 0;
    do begin tick(); c++; end while (req_done == '0 && c < 30);
    oh = exp_done.pop_front();
    checks++;
    if (req_done !== oh) begin
      errors++;
      $display("FAIL rstw_done: done=%b, required %b", req_done, oh);
    end
  endtask

  task automatic test_ext_addr();
    int c;
    int bad;
    int e;
    logic [63:0] exp_ext;
    logic [NUM_REQ-1:0] oh;
    apply_reset();
    set_desc(1, 2'd2, 64'h0000_0000_0000_1111, 64'h0000_0000_1000_0040, 32'd32, 32'd4, 32'd1, 32'd0);
    set_desc(3, 2'd3, 64'h0000_0000_0000_ABCD, 64'h0000_0000_2000_0000, 32'd77, 32'd9, 32'd5, 32'h40);
    req_valid = 4'b1010;
    exp_grant.push_back(1);
    exp_grant.push_back(3);
    for (int n = 0; n < 2; n++) begin
      c = 0;
      do begin tick(); c++; end while (req_ready == '0 && c < 30);
      e = exp_grant.pop_front();
      oh = '0; oh[e] = 1'b1;
      exp_ext = (e == 1) ? 64'h0000_0000_1000_0040 : 64'h0000_0000_2000_0000;
      checks++;
      if (req_ready !== oh || owner !== 3'(e)) begin
        errors++;
        $display("FAIL ext_grant: ready=%b owner=%0d, required %b owner=%0d", req_ready, owner, oh, e);
      end
      exp_done.push_back(oh);
      req_valid[e] = 1'b0;
      // The requester is free to reuse its inputs once accepted.
      set_desc(e, 2'd0, 64'hDEAD, 64'hDEAD_BEEF, 32'd1, 32'd1, 32'd1, 32'd1);
      if (e == 3) begin
        checks++;
        if (dma_mode !== 2'd3 || dma_int_addr !== 64'hABCD || dma_len !== 32'd77 ||
            dma_stride !== 32'd9 || dma_seg_count !== 32'd5 || dma_seg_stride !== 32'h40 ||
            dma_offset !== '0) begin
          errors++;
          $display("FAIL ext_desc3: mode=%0d int=%h len=%0d stride=%0d segc=%0d segs=%h off=%0d, required 3/abcd/77/9/5/40/0",
                   dma_mode, dma_int_addr, dma_len, dma_stride, dma_seg_count, dma_seg_stride, dma_offset);
        end
      end
      bad = 0;
      c = 0;
      do begin
        if (dma_ext_addr !== exp_ext) bad++;
        tick();
        c++;
      end while (req_done == '0 && c < 30);
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL ext_window: req=%0d bad_cycles=%0d last ext=%h, required %h throughout", e, bad, dma_ext_addr, exp_ext);
      end
      oh = exp_done.pop_front();
      checks++;
      if (req_done !== oh) begin
        errors++;
        $display("FAIL ext_done: done=%b, required %b", req_done, oh);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_queue_full();
    test_idle_hold();
    test_rst_wait();
    test_ext_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_cmd_arbiter.md
Name: dma_cmd_arbiter

Overview:
- Shares one dma_engine command interface among NUM_REQ requesters, such as socket cores, a host-control FSM or a data generator.
- Arbitrates round-robin and latches the winning descriptor.
- Drives dma_enqueue then dma_start, waits for dma_done, and returns a per-requester completion pulse.
- Sits between requester FSMs and dma_engine's dma_* control inputs; it replaces the ad-hoc enqueue/start/done FSMs in each requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 64, width of the internal and external address fields.
- CNT_W, 32, width of len/stride/offset/seg_stride/seg_count/wval fields.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester command pending.
- req_ready  out  NUM_REQ  one-hot accept pulse; descriptor captured this cycle.
- req_mode  in  2*NUM_REQ  packed dma_mode per requester (slice i at [2i+:2]).
- req_int_addr  in  ADDR_W*NUM_REQ  packed internal addresses.
- req_ext_addr  in  ADDR_W*NUM_REQ  packed external addresses.
- req_len  in  CNT_W*NUM_REQ  packed lengths.
- req_stride  in  CNT_W*NUM_REQ  packed strides.
- req_seg_count  in  CNT_W*NUM_REQ  packed segment counts.
- req_seg_stride  in  CNT_W*NUM_REQ  packed segment strides.
- req_done  out  NUM_REQ  one-hot completion pulse to the owner.
- busy  out  1  a command is in flight.
- owner  out  3  index of the current/last grantee.
- dma_enqueue  out  1  to dma_engine.
- dma_start  out  1  to dma_engine.
- dma_mode  out  2  latched descriptor field to dma_engine.
- dma_int_addr  out  ADDR_W  latched descriptor field to dma_engine.
- dma_ext_addr  out  ADDR_W  latched descriptor field to dma_engine.
- dma_len  out  CNT_W  latched descriptor field to dma_engine.
- dma_stride  out  CNT_W  latched descriptor field to dma_engine.
- dma_offset  out  CNT_W  tied 0.
- dma_seg_count  out  CNT_W  latched descriptor field to dma_engine.
- dma_seg_stride  out  CNT_W  latched descriptor field to dma_engine.
- dma_done  in  1  from dma_engine.
- dma_idle  in  1  from dma_engine.
- dma_queue_full  in  1  from dma_engine.

Behaviour:
- Reset:
  - State IDLE; all outputs 0.
  - rr_ptr=0 (priority starts at requester 0).
  - Descriptor register and owner are 0.
- States:
  - IDLE:
    - Enter ARB when any req_valid is set and dma_idle=1.
    - If dma_idle=0, stay in IDLE.
  - ARB (1 cycle):
    - Pick the first set req_valid at or after rr_ptr, wrapping modulo NUM_REQ.
    - Pulse req_ready[g] and latch all descriptor slices of g plus owner=g.
    - rr_ptr <= (g+1) mod NUM_REQ. Go to ENQ.
    - If req_valid dropped to zero by ARB, return to IDLE with no grant.
  - ENQ:
    - If dma_queue_full=1, stay with dma_enqueue=0.
    - Otherwise assert dma_enqueue for exactly 1 cycle, then go to START.
  - START: dma_start=1 for 1 cycle, then go to WAIT.
  - WAIT:
    - On dma_done=1, pulse req_done[owner] for that same cycle's next edge (registered, 1 cycle).
    - Then go to IDLE.
- Latency:
  - req_valid to req_ready is 2 cycles when idle.
  - req_ready to dma_enqueue is 1 cycle (no queue-full stall).
- Descriptor handling:
  - dma_* descriptor outputs are registered and stable from ENQ through WAIT.
  - Requesters may change their req_* inputs after req_ready.
- Requester protocol:
  - A requester must hold req_valid until req_ready.
  - A requester deasserts req_valid in the cycle after req_ready, unless it has another command.
- Simultaneous events:
  - req_valid rising during WAIT is ignored until IDLE.
  - dma_done in a state other than WAIT is ignored.
  - busy = state != IDLE.
- Fairness: a continuously asserting requester cannot win twice while another valid requester waits.
- rst mid-operation: returns to IDLE immediately and no req_done is issued. Requesters must reissue.

Optional Feature:
- Macro DMA_ARB_STATS_EN. When defined, the block adds output stat_xfers (32-bit) and output stat_stall (32-bit).
- stat_xfers:
  - Counts completed commands.
  - Saturates at 0xFFFFFFFF.
- stat_stall:
  - Counts cycles in ENQ with dma_queue_full=1.
  - Saturates at 0xFFFFFFFF.
- Both counters clear on rst.
- Without the macro, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single requester 0 with mode=1, len=2, dma_done pulsed 5 cycles after dma_start:
  - req_ready[0] arrives 2 cycles after req_valid.
  - dma_enqueue, then dma_start, each 1 cycle.
  - req_done=4'b0001 one cycle after dma_done.
- All four requesters held valid:
  - Grant order is 0,1,2,3,0.
  - Exactly one req_done per grant, matching owner.
- dma_queue_full=1 for 3 cycles in ENQ:
  - dma_enqueue stays 0 for 3 cycles, then pulses once.
  - stat_stall=3 with DMA_ARB_STATS_EN.
- dma_idle=0 while req_valid[2]=1: no grant until dma_idle=1.
- rst asserted during WAIT:
  - All outputs go 0 asynchronously; no req_done.
  - The next grant starts from requester 0.
- Requester 1 with ext_addr=0x1000_0040, then requester 3 with ext_addr=0x2000_0000: dma_ext_addr shows each value exactly during its own ENQ..WAIT window.
